c_element_hs_arbiter: RTL and testbench

Clocked four-phase handshake controller that shares one external C element (`a`, `b`, `rst` inputs, `o` output) among N requesters. It round-robin arbitrates requests, clears the element, drives its `a` input, and synchronizes its `o` output back into the clock domain. It returns a per-requester acknowledge and aborts with an error pulse on timeout. The controller sits between the pipeline's clocked request logic and the asynchronous completion element; the element's `b` input is driven by the shared resource, not by this block.

---
 rtl/c_element_hs_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_c_element_hs_arbiter.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c_element_hs_arbiter.sv
// c_element_hs_arbiter: shares one external C element among N clocked
// requesters. It arbitrates round-robin, clears the element, raises its `a`
// input, waits for the synchronized `o` output, and returns a per-requester
// acknowledge. A stuck element is reported with a one-cycle error pulse.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transaction; sample requests and pick the next winner
// CLEAR   | hold the element in reset for CLR_CYCLES cycles
// RAISE   | raise `a`, load the timeout counter
// WAIT_HI | wait for the element output to rise (timed)
// ACKED   | acknowledge held until the winner drops its request
// LOWER   | drop `a`, load the timeout counter
// WAIT_LO | wait for the element output to fall (timed)
// ABORT   | one-cycle error pulse, element forced back into reset
module c_element_hs_arbiter #(
  parameter int N           = 4,
  parameter int CLR_CYCLES  = 2,
  parameter int TIMEOUT     = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  output logic [N-1:0] ack_o,
  output logic [N-1:0] err_o,
  output logic         c_a_o,
  output logic         c_rst_o,
  input  logic         c_o_i,
  output logic         busy_o
);

  localparam int PW  = $clog2(N);
  localparam int CLW = $clog2(CLR_CYCLES + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RAISE,
    S_WAIT_HI,
    S_ACKED,
    S_LOWER,
    S_WAIT_LO,
    S_ABORT
  } state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          g_q, g_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [PW-1:0]          pick;
  logic [PW-1:0]          ptr_next;
  logic [CLW-1:0]         clr_cnt_q, clr_cnt_d;
  logic [TW-1:0]          to_cnt_q, to_cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   c_o_s;
  logic [N-1:0]           g_oh;
  logic                   c_a_q;
  logic                   c_rst_q;

  // Bring the asynchronous element output into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], c_o_i};
    end
  end

  assign c_o_s = sync_q[SYNC_STAGES-1];

  // Round-robin search: first requester at or above the pointer, wrapping.
  // Scanning from the far end lets the nearest candidate overwrite the rest.
  always_comb begin
    int sum;
    logic [PW-1:0] idx;
    pick = ptr_q;
    sum  = 0;
    idx  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = int'(ptr_q) + k;
      if (sum >= N) sum = sum - N;
      idx = PW'(sum);
      if (req_i[idx]) pick = idx;
    end
  end

  assign ptr_next = (g_q == PW'(N - 1)) ? '0 : g_q + PW'(1);

  // State, winner, pointer and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      g_q       <= '0;
      ptr_q     <= '0;
      clr_cnt_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      ptr_q     <= ptr_d;
      clr_cnt_q <= clr_cnt_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  // Next-state logic; the timeout expires on the cycle the count would hit 0.
  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    ptr_d     = ptr_q;
    clr_cnt_d = clr_cnt_q;
    to_cnt_d  = to_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          g_d       = pick;
          clr_cnt_d = CLW'(CLR_CYCLES - 1);
          state_d   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (clr_cnt_q == '0) begin
          state_d = S_RAISE;
        end else begin
          clr_cnt_d = clr_cnt_q - CLW'(1);
        end
      end
      S_RAISE: begin
        to_cnt_d = TW'(TIMEOUT);
        state_d  = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (c_o_s) begin
          state_d = S_ACKED;
        end else if (to_cnt_q <= TW'(1)) begin
          to_cnt_d = '0;
          state_d  = S_ABORT;
        end else begin
          to_cnt_d = to_cnt_q - TW'(1);
        end
      end
      S_ACKED: begin
        if (!req_i[g_q]) state_d = S_LOWER;
      end
      S_LOWER: begin
        to_cnt_d = TW'(TIMEOUT);
        state_d  = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!c_o_s) begin
          ptr_d   = ptr_next;
          state_d = S_IDLE;
        end else if (to_cnt_q <= TW'(1)) begin
          to_cnt_d = '0;
          state_d  = S_ABORT;
        end else begin
          to_cnt_d = to_cnt_q - TW'(1);
        end
      end
      S_ABORT: begin
        ptr_d   = ptr_next;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Element drives come straight from flops so the asynchronous element never
  // sees decode glitches. The element is held in reset during rst_n and for
  // the first cycle after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_a_q   <= 1'b0;
      c_rst_q <= 1'b1;
    end else begin
      c_a_q   <= state_d inside {S_RAISE, S_WAIT_HI, S_ACKED};
      c_rst_q <= state_d inside {S_CLEAR, S_ABORT};
    end
  end

  // One-hot view of the current winner.
  always_comb begin
    g_oh      = '0;
    g_oh[g_q] = 1'b1;
  end

  assign busy_o  = (state_q != S_IDLE);
  assign gnt_o   = busy_o ? g_oh : '0;
  assign ack_o   = (state_q inside {S_ACKED, S_LOWER, S_WAIT_LO}) ? g_oh : '0;
  assign err_o   = (state_q == S_ABORT) ? g_oh : '0;
  assign c_a_o   = c_a_q;
  assign c_rst_o = c_rst_q;

endmodule

// File: tb/tb_c_element_hs_arbiter.sv
// Bench for c_element_hs_arbiter: a behavioural C element, bench-driven
// requesters and a grant scoreboard fed when requests are raised.
module tb_c_element_hs_arbiter;

  localparam int N  = 4;
  localparam int CLR = 2;
  localparam int TO  = 8;
  localparam int SS  = 2;

  localparam int W_GNT = 0;
  localparam int W_ACK = 1;
  localparam int W_CA  = 2;
  localparam int W_ERR = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req_i = '0;
  logic [N-1:0] gnt_o, ack_o, err_o;
  logic         c_a_o, c_rst_o, busy_o;
  logic         c_o_i;

  int           vectors = 0;
  int           miscompares = 0;
  logic [N-1:0] exp_q[$];
  int           exp_ptr = 0;
  logic [N-1:0] drop_en = '1;
  bit           auto_rearm = 1'b0;
  int           mode = 0;
  logic [2:0]   dly = '0;
  logic         eo = 1'b0;

  c_element_hs_arbiter #(
    .N(N), .CLR_CYCLES(CLR), .TIMEOUT(TO), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .gnt_o(gnt_o), .ack_o(ack_o),
    .err_o(err_o), .c_a_o(c_a_o), .c_rst_o(c_rst_o), .c_o_i(c_o_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // C element: mode 0 follows `a` three cycles late, mode 1 never rises,
  // mode 2 sticks high once risen. `rst` clears it in every mode.
  always @(negedge clk) begin
    dly = {dly[1:0], c_a_o};
    case (mode)
      1:       eo = 1'b0;
      2:       eo = eo | dly[2];
      default: eo = dly[2];
    endcase
    if (c_rst_o) begin
      dly = '0;
      eo  = 1'b0;
    end
    c_o_i = eo;
  end

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] r;
    r = N'(1) << (i % N);
    return r;
  endfunction

  function automatic logic [N-1:0] sb_pop();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  function automatic logic sig(input int which);
    case (which)
      W_GNT:   return |gnt_o;
      W_ACK:   return |ack_o;
      W_CA:    return c_a_o;
      W_ERR:   return |err_o;
      default: return busy_o;
    endcase
  endfunction

  // One clock; requesters drop on ack and optionally re-raise once released.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (ack_o[i] && drop_en[i]) req_i[i] = 1'b0;
      else if (auto_rearm && !gnt_o[i] && !ack_o[i]) req_i[i] = 1'b1;
    end
  endtask

  task automatic wait_sig(input int which, input logic val, output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      n++;
      if (sig(which) === val) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_i = '0;
    mode  = 0;
    repeat (3) @(negedge clk);
    vectors++;
    if (c_rst_o !== 1'b1) begin
      miscompares++; $display("FAIL reset_c_rst: got %b expected 1", c_rst_o);
    end
    vectors++;
    if ({gnt_o, ack_o, err_o, c_a_o, busy_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got gnt=%b ack=%b err=%b a=%b busy=%b expected all 0",
               gnt_o, ack_o, err_o, c_a_o, busy_o);
    end
    rst_n   = 1'b1;
    exp_ptr = 0;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok; int n; logic [N-1:0] e;
    mode    = 0;
    drop_en = '1;
    req_i   = 4'b0001;
    exp_q.push_back(4'b0001);
    wait_sig(W_GNT, 1'b1, ok, n);
    vectors++;
    if (!ok || n != 1) begin
      miscompares++; $display("FAIL single_gnt_latency: got %0d cycles ok=%0d expected 1", n, ok);
    end
    e = sb_pop();
    vectors++;
    if (gnt_o !== e) begin
      miscompares++; $display("FAIL single_gnt: got %b expected %b", gnt_o, e);
    end
    vectors++;
    if (c_rst_o !== 1'b1 || c_a_o !== 1'b0) begin
      miscompares++; $display("FAIL single_clear1: got rst=%b a=%b expected 1 0", c_rst_o, c_a_o);
    end
    step();
    vectors++;
    if (c_rst_o !== 1'b1 || c_a_o !== 1'b0) begin
      miscompares++; $display("FAIL single_clear2: got rst=%b a=%b expected 1 0", c_rst_o, c_a_o);
    end
    step();
    vectors++;
    if (c_rst_o !== 1'b0 || c_a_o !== 1'b1) begin
      miscompares++; $display("FAIL single_raise: got rst=%b a=%b expected 0 1", c_rst_o, c_a_o);
    end
    wait_sig(W_ACK, 1'b1, ok, n);
    vectors++;
    if (!ok || ack_o !== 4'b0001 || c_a_o !== 1'b1) begin
      miscompares++; $display("FAIL single_ack: got ack=%b a=%b expected 0001 1", ack_o, c_a_o);
    end
    step();
    vectors++;
    if (c_a_o !== 1'b0 || ack_o !== 4'b0001 || gnt_o !== 4'b0001) begin
      miscompares++;
      $display("FAIL single_lower: got a=%b ack=%b gnt=%b expected 0 0001 0001", c_a_o, ack_o, gnt_o);
    end
    wait_sig(W_GNT, 1'b0, ok, n);
    vectors++;
    if (!ok || ack_o !== '0 || busy_o !== 1'b0) begin
      miscompares++; $display("FAIL single_release: got ack=%b busy=%b expected 0 0", ack_o, busy_o);
    end
    // pointer is now 1: requester 1 wins over 0, then the search wraps to 0
    req_i = 4'b0011;
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0001);
    repeat (2) begin
      wait_sig(W_GNT, 1'b1, ok, n);
      e = sb_pop();
      vectors++;
      if (!ok || gnt_o !== e) begin
        miscompares++; $display("FAIL single_rr: got %b expected %b", gnt_o, e);
      end
      wait_sig(W_GNT, 1'b0, ok, n);
      vectors++;
      if (!ok) begin
        miscompares++; $display("FAIL single_rr_done: got gnt=%b expected 0", gnt_o);
      end
    end
    exp_ptr = 1;
  endtask

  task automatic test_fairness();
    bit ok; int n; int p; logic [N-1:0] e; logic [N-1:0] prev;
    p          = exp_ptr;
    prev       = '0;
    mode       = 0;
    auto_rearm = 1'b1;
    req_i      = '1;
    for (int k = 0; k < 5; k++) exp_q.push_back(oh(p + k));
    for (int k = 0; k < 5; k++) begin
      wait_sig(W_GNT, 1'b1, ok, n);
      e = sb_pop();
      vectors++;
      if (!ok || gnt_o !== e) begin
        miscompares++; $display("FAIL fair_grant%0d: got %b expected %b", k, gnt_o, e);
      end
      if (k > 0) begin
        vectors++;
        if (n != 1 || gnt_o === prev) begin
          miscompares++;
          $display("FAIL fair_b2b%0d: got gap %0d gnt=%b prev=%b expected gap 1 and a new winner",
                   k, n, gnt_o, prev);
        end
      end
      prev = gnt_o;
      if (k == 4) begin
        auto_rearm = 1'b0;
        req_i      = gnt_o;
      end
      wait_sig(W_GNT, 1'b0, ok, n);
      vectors++;
      if (!ok) begin
        miscompares++; $display("FAIL fair_done%0d: got gnt=%b expected 0", k, gnt_o);
      end
    end
    exp_ptr = (p + 5) % N;
  endtask

  task automatic test_timeout_hi();
    bit ok; int n; int p; logic [N-1:0] e;
    p     = exp_ptr;
    mode  = 1;
    req_i = oh(p) | oh(p + 1);
    exp_q.push_back(oh(p));
    exp_q.push_back(oh(p + 1));
    wait_sig(W_GNT, 1'b1, ok, n);
    e = sb_pop();
    vectors++;
    if (!ok || gnt_o !== e) begin
      miscompares++; $display("FAIL to_hi_grant: got %b expected %b", gnt_o, e);
    end
    wait_sig(W_CA, 1'b1, ok, n);
    wait_sig(W_ERR, 1'b1, ok, n);
    vectors++;
    if (!ok || n != TO + 1) begin
      miscompares++; $display("FAIL to_hi_delay: got %0d cycles after RAISE expected %0d", n, TO + 1);
    end
    vectors++;
    if (err_o !== oh(p) || c_rst_o !== 1'b1 || c_a_o !== 1'b0 || ack_o !== '0 || gnt_o !== oh(p)) begin
      miscompares++;
      $display("FAIL to_hi_abort: got err=%b rst=%b a=%b ack=%b gnt=%b expected err=gnt=%b rst=1 a=0 ack=0",
               err_o, c_rst_o, c_a_o, ack_o, gnt_o, oh(p));
    end
    req_i = req_i & ~oh(p);
    mode  = 0;
    step();
    vectors++;
    if (busy_o !== 1'b0 || err_o !== '0 || gnt_o !== '0) begin
      miscompares++; $display("FAIL to_hi_idle: got busy=%b err=%b gnt=%b expected 0", busy_o, err_o, gnt_o);
    end
    step();
    e = sb_pop();
    vectors++;
    if (gnt_o !== e) begin
      miscompares++; $display("FAIL to_hi_next: got %b expected %b", gnt_o, e);
    end
    wait_sig(W_GNT, 1'b0, ok, n);
    vectors++;
    if (!ok || err_o !== '0) begin
      miscompares++; $display("FAIL to_hi_next_done: got gnt=%b err=%b expected 0 0", gnt_o, err_o);
    end
    exp_ptr = (p + 2) % N;
  endtask

  task automatic test_timeout_lo();
    bit ok; int n; int p; logic [N-1:0] e;
    p     = exp_ptr;
    mode  = 2;
    req_i = oh(p);
    exp_q.push_back(oh(p));
    wait_sig(W_GNT, 1'b1, ok, n);
    e = sb_pop();
    vectors++;
    if (!ok || gnt_o !== e) begin
      miscompares++; $display("FAIL to_lo_grant: got %b expected %b", gnt_o, e);
    end
    wait_sig(W_ACK, 1'b1, ok, n);
    vectors++;
    if (!ok || ack_o !== oh(p)) begin
      miscompares++; $display("FAIL to_lo_ack: got %b expected %b", ack_o, oh(p));
    end
    wait_sig(W_CA, 1'b0, ok, n);
    vectors++;
    if (!ok || n != 1) begin
      miscompares++; $display("FAIL to_lo_lower: got %0d cycles expected 1", n);
    end
    wait_sig(W_ERR, 1'b1, ok, n);
    vectors++;
    if (!ok || n != TO + 1) begin
      miscompares++; $display("FAIL to_lo_delay: got %0d cycles after LOWER expected %0d", n, TO + 1);
    end
    vectors++;
    if (err_o !== oh(p) || ack_o !== '0 || c_rst_o !== 1'b1 || gnt_o !== oh(p)) begin
      miscompares++;
      $display("FAIL to_lo_abort: got err=%b ack=%b rst=%b gnt=%b expected err=gnt=%b ack=0 rst=1",
               err_o, ack_o, c_rst_o, gnt_o, oh(p));
    end
    mode = 0;
    step();
    vectors++;
    if (busy_o !== 1'b0 || gnt_o !== '0 || err_o !== '0) begin
      miscompares++; $display("FAIL to_lo_idle: got busy=%b gnt=%b err=%b expected 0", busy_o, gnt_o, err_o);
    end
    exp_ptr = (p + 1) % N;
  endtask

  task automatic test_reset_mid();
    bit ok; int n; int p; logic [N-1:0] e;
    p     = exp_ptr;
    mode  = 1;
    req_i = oh(p);
    exp_q.push_back(oh(p));
    wait_sig(W_GNT, 1'b1, ok, n);
    e = sb_pop();
    vectors++;
    if (!ok || gnt_o !== e) begin
      miscompares++; $display("FAIL rst_mid_grant: got %b expected %b", gnt_o, e);
    end
    wait_sig(W_CA, 1'b1, ok, n);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (c_rst_o !== 1'b1) begin
      miscompares++; $display("FAIL rst_mid_c_rst: got %b expected 1", c_rst_o);
    end
    vectors++;
    if ({gnt_o, ack_o, err_o, c_a_o, busy_o} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got gnt=%b ack=%b err=%b a=%b busy=%b expected all 0",
               gnt_o, ack_o, err_o, c_a_o, busy_o);
    end
    req_i = '0;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (err_o !== '0 || c_rst_o !== 1'b1) begin
        miscompares++; $display("FAIL rst_mid_hold: got err=%b rst=%b expected 0 1", err_o, c_rst_o);
      end
    end
    mode  = 0;
    rst_n = 1'b1;
    req_i = 4'b0100;
    exp_q.push_back(4'b0100);
    wait_sig(W_GNT, 1'b1, ok, n);
    e = sb_pop();
    vectors++;
    if (!ok || gnt_o !== e) begin
      miscompares++; $display("FAIL rst_mid_regrant: got %b expected %b", gnt_o, e);
    end
    wait_sig(W_GNT, 1'b0, ok, n);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL rst_mid_done: got gnt=%b expected 0", gnt_o);
    end
    exp_ptr = 3;
  endtask

  task automatic test_late_req();
    bit ok; int n; int p; int q; logic [N-1:0] e;
    p       = exp_ptr;
    q       = (p + 1) % N;
    mode    = 0;
    drop_en = ~oh(p);
    req_i   = oh(p);
    exp_q.push_back(oh(p));
    exp_q.push_back(oh(q));
    wait_sig(W_GNT, 1'b1, ok, n);
    e = sb_pop();
    vectors++;
    if (!ok || gnt_o !== e) begin
      miscompares++; $display("FAIL late_first: got %b expected %b", gnt_o, e);
    end
    wait_sig(W_ACK, 1'b1, ok, n);
    vectors++;
    if (!ok || ack_o !== oh(p)) begin
      miscompares++; $display("FAIL late_ack: got %b expected %b", ack_o, oh(p));
    end
    req_i = req_i | oh(q);
    repeat (3) step();
    vectors++;
    if (gnt_o !== oh(p) || ack_o !== oh(p)) begin
      miscompares++; $display("FAIL late_hold: got gnt=%b ack=%b expected %b", gnt_o, ack_o, oh(p));
    end
    req_i   = req_i & ~oh(p);
    drop_en = '1;
    wait_sig(W_GNT, 1'b0, ok, n);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL late_release: got gnt=%b expected 0", gnt_o);
    end
    step();
    e = sb_pop();
    vectors++;
    if (gnt_o !== e) begin
      miscompares++; $display("FAIL late_grant: got %b one cycle after release expected %b", gnt_o, e);
    end
    wait_sig(W_GNT, 1'b0, ok, n);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL late_done: got gnt=%b expected 0", gnt_o);
    end
    exp_ptr = (q + 1) % N;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_timeout_hi();
    test_timeout_lo();
    test_reset_mid();
    test_late_req();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL sb_leftover: got %0d pending grants expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run expected completion before 200000");
    $fatal(1);
  end

endmodule
